// File: rtl/bpu_2bit.sv
// Purpose : fetch-stage next-PC predictor, direct-mapped BTB with 2-bit saturating counters.
// Latency : lookup is combinational (zero cycles); training writes land on the next rising edge.
// Backpr. : none; an update is accepted on every cycle i_upd_valid=1, lookup is always available.
//
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), async active-low reset
//   i_pc       -> o_pc_next        fetch PC in, predicted next PC out
//   o_pred_taken                   BTB hit with counter in WT/ST
//   i_upd_valid/pc/taken/target    EX-stage resolution used for training
//   i_upd_mispred                  mispredict flag, only consumed by the stats counters
//   o_upd_cnt, o_mispred_cnt       stats counters, present only when BPU_STATS_EN is defined
// Optional feature macro: BPU_STATS_EN
module bpu_2bit #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc,
    output logic [31:0] o_pc_next,
    output logic        o_pred_taken,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_mispred
`ifdef BPU_STATS_EN
    ,
    output logic [31:0] o_upd_cnt,
    output logic [31:0] o_mispred_cnt
`endif
);

    localparam int DEPTH = 1 << IDX_W;

    // Target is kept as a word address; the low two PC bits are always zero.
    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
        logic [29:0]      tgt;
        logic [1:0]       ctr;
    } entry_t;

    // Reset leaves counters at WNT so a freshly allocated-free entry never predicts taken.
    localparam entry_t RST_ENTRY = '{vld: 1'b0, tag: '0, tgt: '0, ctr: 2'b01};

    entry_t tbl_q [DEPTH];

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    entry_t           rd_ent;
    logic             rd_hit;

    assign rd_idx = i_pc[IDX_W+1:2];
    assign rd_tag = i_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign rd_ent = tbl_q[rd_idx];
    assign rd_hit = rd_ent.vld && (rd_ent.tag == rd_tag);

    // Reads the registered table only, so a same-cycle update is not visible until next cycle.
    assign o_pred_taken = rd_hit && rd_ent.ctr[1];
    assign o_pc_next    = o_pred_taken ? {rd_ent.tgt, 2'b00} : (i_pc + 32'd4);

    // ---------------- training ----------------
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    entry_t           up_ent;
    logic             up_hit;
    logic             wr_en;
    entry_t           wr_ent;

    assign up_idx = i_upd_pc[IDX_W+1:2];
    assign up_tag = i_upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_ent = tbl_q[up_idx];
    assign up_hit = up_ent.vld && (up_ent.tag == up_tag);

    always_comb begin
        wr_en  = 1'b0;
        wr_ent = up_ent;
        if (i_upd_valid) begin
            if (up_hit) begin
                wr_en = 1'b1;
                if (i_upd_taken) begin
                    wr_ent.ctr = (up_ent.ctr == 2'b11) ? 2'b11 : (up_ent.ctr + 2'd1);
                    wr_ent.tgt = i_upd_target[31:2];
                end else begin
                    wr_ent.ctr = (up_ent.ctr == 2'b00) ? 2'b00 : (up_ent.ctr - 2'd1);
                end
            end else if (i_upd_taken) begin
                // Miss on a taken branch replaces whatever lives at this index.
                wr_en      = 1'b1;
                wr_ent.vld = 1'b1;
                wr_ent.tag = up_tag;
                wr_ent.tgt = i_upd_target[31:2];
                wr_ent.ctr = 2'b10;
            end
            // Miss on a not-taken branch leaves the table alone.
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= RST_ENTRY;
            end
        end else if (wr_en) begin
            tbl_q[up_idx] <= wr_ent;
        end
    end

    // ---------------- optional statistics ----------------
`ifdef BPU_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_upd_cnt     <= '0;
            o_mispred_cnt <= '0;
        end else if (i_upd_valid) begin
            o_upd_cnt <= o_upd_cnt + 32'd1;
            if (i_upd_mispred) begin
                o_mispred_cnt <= o_mispred_cnt + 32'd1;
            end
        end
    end

    logic unused_upd_bits;
    assign unused_upd_bits = ^{i_upd_pc[1:0], i_upd_pc[31:IDX_W+TAG_W+2], i_upd_target[1:0]};
`else
    // Bits that do not take part in indexing/tagging, plus the stats-only mispredict flag.
    logic unused_upd_bits;
    assign unused_upd_bits = ^{i_upd_pc[1:0], i_upd_pc[31:IDX_W+TAG_W+2], i_upd_target[1:0],
                               i_upd_mispred};
`endif

endmodule

// File: tb/tb_bpu_2bit.sv
// Purpose : self-checking bench for bpu_2bit (vector table plus hand-written reset/stats sequences).
// Latency : each vector checks the combinational lookup mid-cycle, its update lands on the next edge.
// Backpr. : none; one vector per clock.
module tb_bpu_2bit;

    logic        i_clk;
    logic        i_rst_n;
    logic [31:0] i_pc;
    logic [31:0] o_pc_next;
    logic        o_pred_taken;
    logic        i_upd_valid;
    logic [31:0] i_upd_pc;
    logic        i_upd_taken;
    logic [31:0] i_upd_target;
    logic        i_upd_mispred;
`ifdef BPU_STATS_EN
    logic [31:0] o_upd_cnt;
    logic [31:0] o_mispred_cnt;
`endif

    bpu_2bit #(.IDX_W(4), .TAG_W(8)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_pc         (i_pc),
        .o_pc_next    (o_pc_next),
        .o_pred_taken (o_pred_taken),
        .i_upd_valid  (i_upd_valid),
        .i_upd_pc     (i_upd_pc),
        .i_upd_taken  (i_upd_taken),
        .i_upd_target (i_upd_target),
        .i_upd_mispred(i_upd_mispred)
`ifdef BPU_STATS_EN
        ,
        .o_upd_cnt    (o_upd_cnt),
        .o_mispred_cnt(o_mispred_cnt)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // One row: lookup PC with the expected prediction (against the table as it stands
    // before this row's update), plus the update applied at the following rising edge.
    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic [31:0] pc;
        logic        et;
        logic [31:0] en;
    } vec_t;

    vec_t        vq[$];
    logic [32:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    task automatic check_pred(input string name);
        logic [32:0] exp_v;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got taken=%0b next=%08h", name, o_pred_taken, o_pc_next);
        end else begin
            exp_v = exp_q.pop_front();
            if ({o_pred_taken, o_pc_next} !== exp_v) begin
                bad++;
                $display("FAIL %s: got taken=%0b next=%08h, want taken=%0b next=%08h",
                         name, o_pred_taken, o_pc_next, exp_v[32], exp_v[31:0]);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge i_clk);
        i_upd_valid   = v.uv;
        i_upd_pc      = v.upc;
        i_upd_taken   = v.ut;
        i_upd_target  = v.utgt;
        i_upd_mispred = 1'b0;
        i_pc          = v.pc;
        exp_q.push_back({v.et, v.en});
        #1;
        check_pred($sformatf("vec%0d", idx));
    endtask

    task automatic upd_stats(input logic [31:0] pc, input logic t, input logic m);
        @(negedge i_clk);
        i_upd_valid   = 1'b1;
        i_upd_pc      = pc;
        i_upd_taken   = t;
        i_upd_target  = 32'h400;
        i_upd_mispred = m;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //         uv    upc           ut    utgt          pc            et    en
        vq.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        32'h100,      1'b0, 32'h104});   // 0 cold miss
        vq.push_back('{1'b1, 32'h100,      1'b1, 32'h200,      32'h100,      1'b0, 32'h104});   // 1 alloc, same-cycle sees old
        vq.push_back('{1'b1, 32'h100,      1'b0, 32'h0,        32'h100,      1'b1, 32'h200});   // 2 WT hit; ->WNT
        vq.push_back('{1'b1, 32'h100,      1'b0, 32'h0,        32'h100,      1'b0, 32'h104});   // 3 WNT; ->SNT
        vq.push_back('{1'b1, 32'h100,      1'b0, 32'h0,        32'h100,      1'b0, 32'h104});   // 4 SNT stays
        vq.push_back('{1'b1, 32'h100,      1'b1, 32'h200,      32'h100,      1'b0, 32'h104});   // 5 ->WNT
        vq.push_back('{1'b1, 32'h100,      1'b1, 32'h200,      32'h100,      1'b0, 32'h104});   // 6 WNT; ->WT
        vq.push_back('{1'b1, 32'h100,      1'b1, 32'h200,      32'h100,      1'b1, 32'h200});   // 7 ->ST
        vq.push_back('{1'b1, 32'h100,      1'b1, 32'h200,      32'h100,      1'b1, 32'h200});   // 8 ST saturates
        vq.push_back('{1'b1, 32'h100,      1'b0, 32'h0,        32'h100,      1'b1, 32'h200});   // 9 ST; ->WT
        vq.push_back('{1'b1, 32'h100,      1'b0, 32'h0,        32'h100,      1'b1, 32'h200});   // 10 WT; ->WNT
        vq.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        32'h100,      1'b0, 32'h104});   // 11 WNT
        vq.push_back('{1'b1, 32'h100,      1'b1, 32'h280,      32'h100,      1'b0, 32'h104});   // 12 ->WT, new target
        vq.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        32'h100,      1'b1, 32'h280});   // 13 retargeted
        vq.push_back('{1'b1, 32'h140,      1'b1, 32'h300,      32'h140,      1'b0, 32'h144});   // 14 alias replaces entry 0
        vq.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        32'h100,      1'b0, 32'h104});   // 15 old tag misses
        vq.push_back('{1'b1, 32'h100,      1'b0, 32'h0,        32'h140,      1'b1, 32'h300});   // 16 miss+NT: no change
        vq.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        32'h140,      1'b1, 32'h300});   // 17 still 0x140
        vq.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        32'hFFFFFFFC, 1'b0, 32'h0});     // 18 +4 wraps
        vq.push_back('{1'b1, 32'h107,      1'b1, 32'h1003,     32'h104,      1'b0, 32'h108});   // 19 low bits ignored
        vq.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        32'h104,      1'b1, 32'h1000});  // 20
        vq.push_back('{1'b0, 32'h108,      1'b1, 32'h500,      32'h108,      1'b0, 32'h10C});   // 21 valid=0 ignored
        vq.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        32'h108,      1'b0, 32'h10C});   // 22

        i_rst_n       = 1'b0;
        i_pc          = 32'h100;
        i_upd_valid   = 1'b0;
        i_upd_pc      = 32'h0;
        i_upd_taken   = 1'b0;
        i_upd_target  = 32'h0;
        i_upd_mispred = 1'b0;
        #2;
        exp_q.push_back({1'b0, 32'h104});
        check_pred("reset_state");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i], i);
        end

        // Reset asserted mid-training: table clears at once and the coincident update is dropped.
        @(negedge i_clk);
        i_upd_valid  = 1'b1;
        i_upd_pc     = 32'h108;
        i_upd_taken  = 1'b1;
        i_upd_target = 32'h500;
        i_pc         = 32'h140;
        exp_q.push_back({1'b1, 32'h300});
        #1;
        check_pred("pre_rst");
        #1;
        i_rst_n = 1'b0;
        exp_q.push_back({1'b0, 32'h144});
        #1;
        check_pred("async_clr_140");
        i_pc = 32'h104;
        exp_q.push_back({1'b0, 32'h108});
        #1;
        check_pred("async_clr_104");
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n     = 1'b1;
        i_upd_valid = 1'b0;
        i_pc        = 32'h108;
        exp_q.push_back({1'b0, 32'h10C});
        #1;
        check_pred("no_upd_in_rst");

`ifdef BPU_STATS_EN
        check_val("upd_cnt_rst", o_upd_cnt, 32'd0);
        check_val("mispred_cnt_rst", o_mispred_cnt, 32'd0);
        upd_stats(32'h200, 1'b1, 1'b1);
        upd_stats(32'h200, 1'b0, 1'b0);
        upd_stats(32'h204, 1'b0, 1'b0);
        @(negedge i_clk);
        i_upd_valid   = 1'b0;
        i_upd_mispred = 1'b1;
        @(negedge i_clk);
        #1;
        check_val("upd_cnt", o_upd_cnt, 32'd3);
        check_val("mispred_cnt", o_mispred_cnt, 32'd1);
`endif

        // Relearn after reset to show the table is usable again.
        apply('{1'b1, 32'h100, 1'b1, 32'h200, 32'h100, 1'b0, 32'h104}, 100);
        apply('{1'b0, 32'h0,   1'b0, 32'h0,   32'h100, 1'b1, 32'h200}, 101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
